// File: rtl/processor_pkg.sv
// -----------------------------------------------------------------------------
// processor_pkg
// Types and constants shared by the multicycle controller and its ALU decoder.
// It holds the controller state enum, the ALU command encoding, the op-field
// constants, the datapath select encodings and the data-processing cmd codes.
// -----------------------------------------------------------------------------
package processor_pkg;

   // Controller states
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } main_state_e;

   // ALU command seen by the datapath
   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctrl_e;

   // Instruction op field, bits [27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRC_B_REG  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Data-processing cmd field, funct[4:1]
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // Register number of the program counter
   localparam logic [3:0] RD_PC = 4'hF;

   // Register-file read-port source selects derived from the op field:
   // bit 0 selects PC for branches, bit 1 selects Rd for stores.
   function automatic logic [1:0] reg_src_of(input logic [1:0] op);
      return {(op == OP_MEM), (op == OP_BR)};
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational decode of the data-processing cmd into an ALU command and the
// flag-write enables. When not enabled it requests ADD with no flag writes, so
// address and PC arithmetic in the other controller states is unaffected.
//
// Ports:
//   funct_i        in   6  instruction [25:20]: I bit, cmd[3:0], S bit
//   alu_op_i       in   1  cmd decode enable (execute states only)
//   alu_control_o  out  2  ALU command (ADD/SUB/AND/ORR)
//   flag_write_o   out  2  [1] = N,Z enable, [0] = C,V enable
// -----------------------------------------------------------------------------
module alu_decoder
   import processor_pkg::*;
(
   input  logic [5:0] funct_i,
   input  logic       alu_op_i,
   output logic [1:0] alu_control_o,
   output logic [1:0] flag_write_o
);

   alu_ctrl_e alu_ctrl_s;
   logic      legal_s;
   logic      arith_s;

   // Map the cmd field to an ALU command; unknown cmds fall back to ADD
   always_comb begin
      alu_ctrl_s = ALU_ADD;
      legal_s    = 1'b0;
      if (alu_op_i) begin
         case (funct_i[4:1])
            CMD_ADD: begin alu_ctrl_s = ALU_ADD; legal_s = 1'b1; end
            CMD_SUB: begin alu_ctrl_s = ALU_SUB; legal_s = 1'b1; end
            CMD_AND: begin alu_ctrl_s = ALU_AND; legal_s = 1'b1; end
            CMD_ORR: begin alu_ctrl_s = ALU_ORR; legal_s = 1'b1; end
            default: begin alu_ctrl_s = ALU_ADD; legal_s = 1'b0; end
         endcase
      end else begin
         alu_ctrl_s = ALU_ADD;
         legal_s    = 1'b0;
      end
   end

   // C and V only carry meaning for arithmetic commands
   always_comb begin
      arith_s      = (alu_ctrl_s == ALU_ADD) || (alu_ctrl_s == ALU_SUB);
      flag_write_o = 2'b00;
      if (alu_op_i && legal_s) begin
         flag_write_o = {funct_i[0], funct_i[0] & arith_s};
      end else begin
         flag_write_o = 2'b00;
      end
   end

   assign alu_control_o = alu_ctrl_s;

endmodule

// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm
// Multicycle main controller. Walks each instruction through fetch, decode,
// execute, memory and write-back, drives the datapath selects, and raises the
// unconditional write requests that the condition logic later gates.
//
// Ports:
//   clk_i          in   1  clock, rising edge
//   rst_i          in   1  synchronous active-low reset
//   op_i           in   2  instruction [27:26]
//   funct_i        in   6  instruction [25:20]
//   rd_i           in   4  destination register, instruction [15:12]
//   ir_write_o     out  1  instruction register load
//   next_pc_o      out  1  PC <= PC+4
//   adr_src_o      out  1  memory address: 0 = PC, 1 = ALU result
//   alu_src_a_o    out  1  0 = register A, 1 = PC
//   alu_src_b_o    out  2  00 = reg B, 01 = immediate, 10 = constant 4
//   result_src_o   out  2  00 = ALU out reg, 01 = data reg, 10 = ALU result
//   alu_control_o  out  2  ALU command
//   imm_src_o      out  2  immediate extension select (follows op)
//   reg_src_o      out  2  register read-port source selects
//   pcs_o          out  1  PC written by the instruction
//   reg_write_o    out  1  register write request
//   mem_write_o    out  1  memory write request
//   flag_write_o   out  2  flag write enables
// -----------------------------------------------------------------------------
module main_fsm
   import processor_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] op_i,
   input  logic [5:0] funct_i,
   input  logic [3:0] rd_i,
   output logic       ir_write_o,
   output logic       next_pc_o,
   output logic       adr_src_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] result_src_o,
   output logic [1:0] alu_control_o,
   output logic [1:0] imm_src_o,
   output logic [1:0] reg_src_o,
   output logic       pcs_o,
   output logic       reg_write_o,
   output logic       mem_write_o,
   output logic [1:0] flag_write_o
);

   main_state_e state_q;
   main_state_e state_d;
   main_state_e out_state_s;

   logic ir_write_s;
   logic next_pc_s;
   logic reg_write_s;
   logic mem_write_s;
   logic branch_s;
   logic alu_op_s;
   logic [1:0] flag_write_s;

   // State register with synchronous active-low reset into FETCH
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (op_i)
               OP_DP:   state_d = funct_i[5] ? S_EXECUTEI : S_EXECUTER;
               OP_MEM:  state_d = S_MEMADR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;   // illegal op: abandon silently
            endcase
         end
         S_MEMADR:   state_d = funct_i[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // While in reset the selects present their FETCH values regardless of
   // where the state register currently sits.
   assign out_state_s = rst_i ? state_q : S_FETCH;

   // Moore decode of selects and raw write strobes
   always_comb begin
      ir_write_s   = 1'b0;
      next_pc_s    = 1'b0;
      adr_src_o    = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRC_B_REG;
      result_src_o = RES_ALUOUT;
      reg_write_s  = 1'b0;
      mem_write_s  = 1'b0;
      branch_s     = 1'b0;
      alu_op_s     = 1'b0;
      case (out_state_s)
         S_FETCH: begin
            ir_write_s   = 1'b1;
            next_pc_s    = 1'b1;
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = SRC_B_FOUR;
            result_src_o = RES_ALU;
         end
         S_DECODE: begin
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = SRC_B_FOUR;
            result_src_o = RES_ALU;
         end
         S_MEMADR: begin
            alu_src_b_o  = SRC_B_IMM;
         end
         S_MEMREAD: begin
            adr_src_o    = 1'b1;
         end
         S_MEMWB: begin
            result_src_o = RES_DATA;
            reg_write_s  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src_o    = 1'b1;
            mem_write_s  = 1'b1;
         end
         S_EXECUTER: begin
            alu_op_s     = 1'b1;
         end
         S_EXECUTEI: begin
            alu_src_b_o  = SRC_B_IMM;
            alu_op_s     = 1'b1;
         end
         S_ALUWB: begin
            reg_write_s  = 1'b1;
         end
         S_BRANCH: begin
            alu_src_b_o  = SRC_B_IMM;
            result_src_o = RES_ALU;
            branch_s     = 1'b1;
         end
         default: begin
            alu_src_a_o  = 1'b1;
            alu_src_b_o  = SRC_B_FOUR;
            result_src_o = RES_ALU;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .funct_i       (funct_i),
      .alu_op_i      (alu_op_s),
      .alu_control_o (alu_control_o),
      .flag_write_o  (flag_write_s)
   );

   // Strobes are suppressed for the whole reset cycle so an aborted
   // instruction leaves no side effects.
   assign ir_write_o   = rst_i & ir_write_s;
   assign next_pc_o    = rst_i & next_pc_s;
   assign reg_write_o  = rst_i & reg_write_s;
   assign mem_write_o  = rst_i & mem_write_s;
   assign flag_write_o = rst_i ? flag_write_s : 2'b00;
   assign pcs_o        = rst_i & (branch_s | (reg_write_s & (rd_i == RD_PC)));

   assign imm_src_o = op_i;
   assign reg_src_o = reg_src_of(op_i);

endmodule
